cgra_config_sequencer: RTL

Context sequencer that drives the config_frame/config_valid port of one cgra_pe. It holds a small context memory of 64-bit configuration frames, written by the host while idle. On start it replays contexts 0..num_ctx-1 cyclically for iter_count iterations, one frame per non-stalled cycle. It reports busy/done/err back to the array-level controller.

---
 rtl/cgra_ctrl_pkg.sv | 43 ++++
 rtl/cgra_config_sequencer_if.sv | 36 +++
 rtl/cgra_ctx_mem.sv | 26 ++
 rtl/cgra_config_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cgra_ctrl_pkg.sv
// Shared CGRA control types: sequencer state, config-frame field layout
// (common with cgra_pe) and opcode constants.
package cgra_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned CFG_WIDTH = 64;

  localparam int unsigned OPC_LSB      = 0;
  localparam int unsigned OPC_MSB      = 5;
  localparam int unsigned SRC0_LSB     = 6;
  localparam int unsigned SRC0_MSB     = 9;
  localparam int unsigned SRC1_LSB     = 10;
  localparam int unsigned SRC1_MSB     = 13;
  localparam int unsigned DST_LSB      = 14;
  localparam int unsigned DST_MSB      = 17;
  localparam int unsigned ROUTE_LSB    = 18;
  localparam int unsigned ROUTE_MSB    = 21;
  localparam int unsigned PRED_EN_BIT  = 22;
  localparam int unsigned PRED_INV_BIT = 23;
  localparam int unsigned IMM_LSB      = 24;
  localparam int unsigned IMM_MSB      = 39;

  localparam logic [5:0] OP_ADD    = 6'd1;
  localparam logic [5:0] OP_MUL    = 6'd3;
  localparam logic [5:0] OP_MAC    = 6'd4;
  localparam logic [5:0] OP_CMP_GT = 6'd10;
  localparam logic [5:0] OP_PASS0  = 6'd16;

  function automatic logic [CFG_WIDTH-1:0] make_frame(input logic [5:0] op,
                                                      input logic [15:0] imm);
    logic [CFG_WIDTH-1:0] f;
    f = '0;
    f[OPC_MSB:OPC_LSB] = op;
    f[IMM_MSB:IMM_LSB] = imm;
    return f;
  endfunction

endpackage

// File: rtl/cgra_config_sequencer_if.sv
// Host/controller <-> config sequencer bundle: context writes, run control,
// issued frame to the PE and status pulses.
interface cgra_config_sequencer_if #(
    parameter int unsigned CFG_WIDTH  = cgra_ctrl_pkg::CFG_WIDTH,
    parameter int unsigned CTX_DEPTH  = 16,
    parameter int unsigned ITER_WIDTH = 16,
    parameter int unsigned CTX_AW     = $clog2(CTX_DEPTH)
);
    logic                  ctx_wr_en;
    logic [CTX_AW-1:0]     ctx_wr_addr;
    logic [CFG_WIDTH-1:0]  ctx_wr_data;
    logic                  start;
    logic [CTX_AW:0]       num_ctx;
    logic [ITER_WIDTH-1:0] iter_count;
    logic                  stall;
    logic                  abort;
    logic [CFG_WIDTH-1:0]  config_frame;
    logic                  config_valid;
    logic [CTX_AW-1:0]     cur_ctx;
    logic [ITER_WIDTH-1:0] cur_iter;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output ctx_wr_en, ctx_wr_addr, ctx_wr_data, start, num_ctx, iter_count,
               stall, abort,
        input  config_frame, config_valid, cur_ctx, cur_iter, busy, done, err
    );

    modport slave (
        input  ctx_wr_en, ctx_wr_addr, ctx_wr_data, start, num_ctx, iter_count,
               stall, abort,
        output config_frame, config_valid, cur_ctx, cur_iter, busy, done, err
    );
endinterface

// File: rtl/cgra_ctx_mem.sv
// Context register file: synchronous write, combinational read, cleared on rst.
module cgra_ctx_mem #(
    parameter int unsigned CFG_WIDTH = 64,
    parameter int unsigned CTX_DEPTH = 16,
    parameter int unsigned CTX_AW    = $clog2(CTX_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CTX_AW-1:0]    wr_addr,
    input  logic [CFG_WIDTH-1:0] wr_data,
    input  logic [CTX_AW-1:0]    rd_addr,
    output logic [CFG_WIDTH-1:0] rd_data
);
    logic [CFG_WIDTH-1:0] mem [CTX_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CTX_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/cgra_config_sequencer.sv
// Replays contexts 0..n-1 for iters iterations into one cgra_pe config port,
// one frame per non-stalled cycle, with busy/done/err status.
module cgra_config_sequencer
    import cgra_ctrl_pkg::*;
#(
    parameter int unsigned CFG_WIDTH  = cgra_ctrl_pkg::CFG_WIDTH,
    parameter int unsigned CTX_DEPTH  = 16,
    parameter int unsigned CTX_AW     = $clog2(CTX_DEPTH),
    parameter int unsigned ITER_WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst,
    cgra_config_sequencer_if.slave bus
);
    localparam logic [CTX_AW:0] MAX_N = CTX_DEPTH[CTX_AW:0];

    state_e                state, state_d;
    logic [CTX_AW-1:0]     ptr, ptr_d;
    logic [ITER_WIDTH-1:0] it, it_d, iters, iters_d;
    logic [CTX_AW:0]       n, n_d;
    logic [CFG_WIDTH-1:0]  rd_data, frame_d;
    logic [CTX_AW-1:0]     cur_ctx_d;
    logic [ITER_WIDTH-1:0] cur_iter_d;
    logic                  valid_d, busy_d, done_d, err_d;
    logic                  start_ok, last_ctx, last_iter, issue;

    assign start_ok  = bus.start && (bus.num_ctx != '0) && (bus.num_ctx <= MAX_N)
                       && (bus.iter_count != '0);
    assign last_ctx  = ({1'b0, ptr} == (n - 1'b1));
    assign last_iter = (it == (iters - 1'b1));
    assign issue     = (state == RUN) && !bus.abort && !bus.stall;

    cgra_ctx_mem #(
        .CFG_WIDTH(CFG_WIDTH),
        .CTX_DEPTH(CTX_DEPTH),
        .CTX_AW   (CTX_AW)
    ) u_ctx_mem (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (bus.ctx_wr_en && (state == IDLE)),
        .wr_addr(bus.ctx_wr_addr),
        .wr_data(bus.ctx_wr_data),
        .rd_addr(ptr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            it               <= '0;
            n                <= '0;
            iters            <= '0;
            bus.config_frame <= '0;
            bus.config_valid <= 1'b0;
            bus.cur_ctx      <= '0;
            bus.cur_iter     <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            state            <= state_d;
            ptr              <= ptr_d;
            it               <= it_d;
            n                <= n_d;
            iters            <= iters_d;
            bus.config_frame <= frame_d;
            bus.config_valid <= valid_d;
            bus.cur_ctx      <= cur_ctx_d;
            bus.cur_iter     <= cur_iter_d;
            bus.busy         <= busy_d;
            bus.done         <= done_d;
            bus.err          <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_ok) state_d = RUN;
            RUN: begin
                if (bus.abort) state_d = IDLE;
                else if (!bus.stall && last_ctx && last_iter) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and run counters.
    always_comb begin
        ptr_d      = ptr;
        it_d       = it;
        n_d        = n;
        iters_d    = iters;
        frame_d    = bus.config_frame;
        cur_ctx_d  = bus.cur_ctx;
        cur_iter_d = bus.cur_iter;
        valid_d    = 1'b0;
        busy_d     = (state_d != IDLE);
        done_d     = (state == DONE);
        err_d      = bus.ctx_wr_en && (state != IDLE);

        if (state == IDLE && bus.start) begin
            if (start_ok) begin
                n_d     = bus.num_ctx;
                iters_d = bus.iter_count;
                ptr_d   = '0;
                it_d    = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (issue) begin
            frame_d    = rd_data;
            valid_d    = 1'b1;
            cur_ctx_d  = ptr;
            cur_iter_d = it;
            if (last_ctx) begin
                ptr_d = '0;
                if (!last_iter) it_d = it + 1'b1;
            end else begin
                ptr_d = ptr + 1'b1;
            end
        end
    end
endmodule
